// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: gates the raster on a synchronised PLL lock flag and
// emits registered, mutually aligned sync/enable/coordinate outputs.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start,
  output logic       running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  state_t     state_q;
  logic       lock_meta_q, lock_s_q;
  logic [9:0] x_q, y_q;
  logic [9:0] x_d, y_d;
  logic       hsync_q, vsync_q, de_q, line_start_q, frame_start_q, running_q;
  logic       x_wrap;

  // Next coordinate: advance only while staying in RUN; any entry into RUN starts at (0,0).
  always_comb begin
    x_wrap = (x_q == H_LAST);
    x_d    = '0;
    y_d    = '0;
    if (state_q == RUN && lock_s_q) begin
      x_d = x_wrap ? 10'd0 : x_q + 10'd1;
      if (x_wrap) begin
        y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        y_d = y_q;
      end
    end
  end

  // Outputs are decoded from the next coordinate so they line up with pixel_x/pixel_y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      state_q       <= WAIT_LOCK;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      lock_meta_q <= locked;
      lock_s_q    <= lock_meta_q;
      case (state_q)
        WAIT_LOCK: if (lock_s_q)  state_q <= RUN;
        RUN:       if (!lock_s_q) state_q <= WAIT_LOCK;
        default:                  state_q <= WAIT_LOCK;
      endcase
      x_q <= x_d;
      y_q <= y_d;
      if (lock_s_q) begin
        hsync_q       <= !((x_d >= H_SYNC_BEG) && (x_d < H_SYNC_END));
        vsync_q       <= !((y_d >= V_SYNC_BEG) && (y_d < V_SYNC_END));
        de_q          <= (x_d < H_ACT) && (y_d < V_ACT);
        line_start_q  <= (x_d == 10'd0);
        frame_start_q <= (x_d == 10'd0) && (y_d == 10'd0);
        running_q     <= 1'b1;
      end else begin
        hsync_q       <= 1'b1;
        vsync_q       <= 1'b1;
        de_q          <= 1'b0;
        line_start_q  <= 1'b0;
        frame_start_q <= 1'b0;
        running_q     <= 1'b0;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus a shrunken-raster instance so whole
// frames fit in a short run; both are checked every cycle against a time-based raster model.
module tb_vga_timing_gen;

  localparam int SHA = 32, SHF = 4, SHS = 8, SHB = 4;
  localparam int SVA = 24, SVF = 3, SVS = 2, SVB = 5;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked = 1'b0;

  logic       d_hs, d_vs, d_de, d_ls, d_fs, d_run;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_de, s_ls, s_fs, s_run;
  logic [9:0] s_x, s_y;
  logic [25:0] dvec, svec;

  int checks = 0;
  int errors = 0;

  // Model: running after an edge iff locked was seen high two edges earlier;
  // rt counts clocks since the raster last (re)started.
  logic [1:0] hist = 2'b00;
  bit         mrun = 1'b0;
  int         rt   = 0;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .locked(locked),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .pixel_x(d_x), .pixel_y(d_y),
    .line_start(d_ls), .frame_start(d_fs), .running(d_run)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_s (
    .clk(clk), .rst(rst), .locked(locked),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .pixel_x(s_x), .pixel_y(s_y),
    .line_start(s_ls), .frame_start(s_fs), .running(s_run)
  );

  assign dvec = {d_hs, d_vs, d_de, d_ls, d_fs, d_run, d_x, d_y};
  assign svec = {s_hs, s_vs, s_de, s_ls, s_fs, s_run, s_x, s_y};

  always #20 clk = ~clk;

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  function automatic logic [25:0] exp_vec(bit run, int t, int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, int vb);
    int ht, vt, x, y;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    x  = t % ht;
    y  = (t / ht) % vt;
    if (!run) return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
    return {!(x >= ha + hf && x < ha + hf + hs), !(y >= va + vf && y < va + vf + vs),
            (x < ha && y < va), (x == 0), (x == 0 && y == 0), 1'b1, 10'(x), 10'(y)};
  endfunction

  function automatic logic [51:0] exp_both();
    return {exp_vec(mrun, rt, 640, 16, 96, 48, 480, 10, 2, 33),
            exp_vec(mrun, rt, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB)};
  endfunction

  function automatic bit small_at(int x, int y);
    return mrun && (rt % SHT == x) && ((rt / SHT) % SVT == y);
  endfunction

  // Advance one clock (inputs stable at the edge), update the model, return at the negedge.
  task automatic tick();
    bit nr;
    @(posedge clk);
    if (rst) begin
      hist = 2'b00; mrun = 1'b0; rt = 0;
    end else begin
      nr   = hist[1];
      hist = {hist[0], locked};
      rt   = (nr && mrun) ? rt + 1 : 0;
      mrun = nr;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({dvec, svec} !== exp_both()) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, {dvec, svec}, exp_both());
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({dvec, svec} !== exp_both()) begin
        errors++;
        $display("FAIL reset_release edge=%0d got=%h exp=%h", i + 1, {dvec, svec}, exp_both());
      end
    end
    checks++;
    if ({d_run, d_fs, d_ls, d_de, s_run, s_fs} !== 6'b111111) begin
      errors++;
      $display("FAIL acquire_edge3 got=%b exp=111111", {d_run, d_fs, d_ls, d_de, s_run, s_fs});
    end
    $display("test_reset done");
  endtask

  task automatic test_no_lock();
    locked = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      checks++;
      if ({dvec, svec} !== exp_both()) begin
        errors++;
        $display("FAIL no_lock cyc=%0d got=%h exp=%h", i, {dvec, svec}, exp_both());
      end
    end
    $display("test_no_lock done");
  endtask

  task automatic test_line_frame();
    int n, wait_cnt;
    int s_hs_lo, s_vs_lo, s_de_hi, s_fs_cnt, s_ls_cnt, s_fs_last;
    int d_hs_lo, d_de_hi, d_ls_cnt;
    n = 2 * SHT * SVT;
    s_hs_lo = 0; s_vs_lo = 0; s_de_hi = 0; s_fs_cnt = 0; s_ls_cnt = 0; s_fs_last = -1;
    d_hs_lo = 0; d_de_hi = 0; d_ls_cnt = 0; wait_cnt = 0;
    locked = 1'b1;
    while (!mrun && wait_cnt < 8) begin
      tick();
      wait_cnt++;
      checks++;
      if ({dvec, svec} !== exp_both()) begin
        errors++;
        $display("FAIL lf_acquire cyc=%0d got=%h exp=%h", wait_cnt, {dvec, svec}, exp_both());
      end
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      checks++;
      if ({dvec, svec} !== exp_both()) begin
        errors++;
        $display("FAIL line_frame t=%0d got=%h exp=%h", rt, {dvec, svec}, exp_both());
      end
      if (i < SHT * SVT) begin
        s_hs_lo += (s_hs == 1'b0) ? 1 : 0;
        s_vs_lo += (s_vs == 1'b0) ? 1 : 0;
        s_de_hi += (s_de == 1'b1) ? 1 : 0;
        s_ls_cnt += (s_ls == 1'b1) ? 1 : 0;
      end
      if (s_fs) begin s_fs_cnt++; s_fs_last = i; end
      if (i < 800) begin
        d_hs_lo += (d_hs == 1'b0) ? 1 : 0;
        d_de_hi += (d_de == 1'b1) ? 1 : 0;
      end
      d_ls_cnt += (d_ls == 1'b1) ? 1 : 0;
    end
    checks++;
    if ({s_hs_lo, s_vs_lo, s_de_hi, s_ls_cnt} !== {SHS * SVT, SVS * SHT, SHA * SVA, SVT}) begin
      errors++;
      $display("FAIL frame_counts got hs=%0d vs=%0d de=%0d ls=%0d exp %0d %0d %0d %0d",
               s_hs_lo, s_vs_lo, s_de_hi, s_ls_cnt, SHS * SVT, SVS * SHT, SHA * SVA, SVT);
    end
    checks++;
    if (s_fs_cnt !== 2 || s_fs_last !== SHT * SVT) begin
      errors++;
      $display("FAIL frame_period got cnt=%0d last=%0d exp cnt=2 last=%0d",
               s_fs_cnt, s_fs_last, SHT * SVT);
    end
    checks++;
    if (d_hs_lo !== 96 || d_de_hi !== 640 || d_ls_cnt !== (n + 799) / 800) begin
      errors++;
      $display("FAIL line0_counts got hs=%0d de=%0d ls=%0d exp 96 640 %0d",
               d_hs_lo, d_de_hi, d_ls_cnt, (n + 799) / 800);
    end
    $display("test_line_frame done");
  endtask

  task automatic test_lock_loss();
    int guard, idle_len, run_len;
    guard = 0;
    while (!small_at(30, 20) && guard < 4000) begin
      tick();
      guard++;
      checks++;
      if ({dvec, svec} !== exp_both()) begin
        errors++;
        $display("FAIL ll_seek t=%0d got=%h exp=%h", rt, {dvec, svec}, exp_both());
      end
    end
    checks++;
    if (!small_at(30, 20)) begin
      errors++;
      $display("FAIL ll_seek_timeout got pos=none exp x=30 y=20");
    end
    locked = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({dvec, svec} !== exp_both()) begin
        errors++;
        $display("FAIL lock_drop edge=%0d got=%h exp=%h", i + 1, {dvec, svec}, exp_both());
      end
    end
    checks++;
    if ({d_run, s_run, d_fs, s_fs, d_de} !== 5'b00000) begin
      errors++;
      $display("FAIL lock_drop_idle got=%b exp=00000", {d_run, s_run, d_fs, s_fs, d_de});
    end
    locked = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({dvec, svec} !== exp_both()) begin
        errors++;
        $display("FAIL relock edge=%0d got=%h exp=%h", i + 1, {dvec, svec}, exp_both());
      end
    end
    checks++;
    if ({d_fs, s_fs, d_x, s_y} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL relock_origin got fs=%b%b x=%0d y=%0d exp fs=11 x=0 y=0", d_fs, s_fs, d_x, s_y);
    end
    for (int k = 0; k < 6; k++) begin
      run_len  = $urandom_range(1, 2500);
      idle_len = $urandom_range(1, 30);
      for (int i = 0; i < run_len + idle_len; i++) begin
        if (i == run_len) locked = 1'b0;
        tick();
        checks++;
        if ({dvec, svec} !== exp_both()) begin
          errors++;
          $display("FAIL rand_lock k=%0d i=%0d got=%h exp=%h", k, i, {dvec, svec}, exp_both());
        end
      end
      locked = 1'b1;
    end
    // Sub-cycle glitch that never spans a rising edge.
    for (int i = 0; i < 60; i++) begin
      if (i == 20) begin #5 locked = 1'b0; #5 locked = 1'b1; end
      tick();
      checks++;
      if ({dvec, svec} !== exp_both()) begin
        errors++;
        $display("FAIL glitch i=%0d got=%h exp=%h", i, {dvec, svec}, exp_both());
      end
    end
    $display("test_lock_loss done");
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    guard = 0;
    while (!small_at(SHA + SHF + SHS + 2, SVA + SVF + SVS - 1) && guard < 4000) begin
      tick();
      guard++;
      checks++;
      if ({dvec, svec} !== exp_both()) begin
        errors++;
        $display("FAIL rm_seek t=%0d got=%h exp=%h", rt, {dvec, svec}, exp_both());
      end
    end
    checks++;
    if (s_vs !== 1'b0) begin
      errors++;
      $display("FAIL rm_seek_pos got vsync=%b exp vsync=0 at reset point", s_vs);
    end
    #3 rst = 1'b1;
    hist = 2'b00; mrun = 1'b0; rt = 0;
    #1;
    checks++;
    if ({dvec, svec} !== exp_both()) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", {dvec, svec}, exp_both());
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) tick();
    rst = 1'b0;
    for (int i = 0; i < 3 + 2 * SHT; i++) begin
      tick();
      checks++;
      if ({dvec, svec} !== exp_both()) begin
        errors++;
        $display("FAIL reset_restart i=%0d got=%h exp=%h", i, {dvec, svec}, exp_both());
      end
    end
    $display("test_reset_mid_frame done");
  endtask

  initial begin
    test_reset();
    test_no_lock();
    test_line_frame();
    test_lock_loss();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
